vnu: RTL and testbench
======================

VNU -- requirements
Module: vnu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port en, input, 1 bit: global clock enable; when 0, every register holds.
REQ-004 SHALL have port llr_load, input, 1 bit: capture channel LLR from llr_in.
REQ-005 SHALL have port llr_in, input, 5 bits: channel LLR, sign-magnitude; bit4 is the sign (1 = negative), [3:0] is the magnitude.
REQ-006 SHALL have port init, input, 1 bit: first-iteration mode; check messages are treated as zero.
REQ-007 SHALL have port in_valid, input, 1 bit: C_in carries a valid beat.
REQ-008 SHALL have port C_in, input, [2:0][4:0]: three check-to-variable messages, each sign-magnitude (bit4 sign, [3:0] magnitude), in the CNU output format.
REQ-009 SHALL have port X_out, output, [2:0][5:0]: three variable-to-check messages; bit5 is the hard decision, bit4 the sign, [3:0] the magnitude, in the CNU input format.
REQ-010 SHALL have port out_valid, output, 1 bit: X_out is valid.
REQ-011 SHALL have port hard_bit, output, 1 bit: hard decision of the last valid beat.
REQ-012 SHALL have port iter_cnt, output, 4 bits: number of accepted beats since the last llr_load.

Function
REQ-013 SHALL convert every sign-magnitude input to 7-bit two's complement; negative zero (sign 1, magnitude 0) SHALL equal 0.
REQ-014 SHALL hold the channel LLR in an internal register, written on a cycle with en=1 and llr_load=1.
REQ-015 On a cycle with llr_load=1 and in_valid=1, stage 1 SHALL use llr_in (bypass), not the stored value.
REQ-016 Stage 1 (en=1, in_valid=1) SHALL register total = L + C0 + C1 + C2 (7-bit signed, no overflow possible, range ±60), plus the three converted C values; when init=1, C0..C2 SHALL be taken as 0.
REQ-017 Stage 2 SHALL compute, per edge i, ext_i = total − C_i (init=1: ext_i = L).
REQ-018 X_out[i][4] SHALL be 1 if and only if ext_i < 0.
REQ-019 X_out[i][3:0] SHALL be min(|ext_i|, 15), saturating.
REQ-020 X_out[i][5] and hard_bit SHALL be 1 if and only if total < 0; total = 0 gives 0.
REQ-021 Latency SHALL be exactly 2 enabled cycles from an accepted in_valid beat to out_valid=1 with the corresponding X_out.
REQ-022 Throughput SHALL be one beat per enabled cycle, with back-to-back beats fully pipelined.
REQ-023 out_valid SHALL be 1 for exactly one enabled cycle per accepted beat; X_out and hard_bit SHALL hold their last valid values while out_valid=0.
REQ-024 With en=0, all pipeline registers, the valid flags, the LLR register and iter_cnt SHALL hold; llr_load and in_valid SHALL be ignored.
REQ-025 iter_cnt SHALL increment on each accepted beat and saturate at 15.
REQ-026 iter_cnt SHALL clear to 0 on llr_load; with simultaneous llr_load and in_valid, iter_cnt SHALL become 1.
REQ-027 Beats already in the pipeline when llr_load occurs SHALL complete with the LLR they captured.

Reset
REQ-028 With rst=1 at a clock edge, regardless of en, the block SHALL clear: LLR register=0, all pipeline registers=0, valid flags=0, iter_cnt=0.
REQ-029 Reset SHALL also drive X_out=all-zero, out_valid=0 and hard_bit=0.
REQ-030 Reset SHALL take priority over llr_load and in_valid in the same cycle; in-flight beats SHALL be discarded and SHALL NOT produce out_valid.

Verification
REQ-031 SHALL cover reset: rst=1 mid-flight with two beats pending -> out_valid stays 0 for the next 3 cycles, X_out=0, iter_cnt=0.
REQ-032 SHALL cover init mode: llr_in=5'b0_0111 with llr_load, then init=1 and in_valid=1 -> 2 cycles later every X_out[i]=6'b00_0111, hard_bit=0, iter_cnt=1.
REQ-033 SHALL cover extrinsic values: L=+7, C_in = {−3 (5'b1_0011), +2, +1} -> X_out[0]=6'b00_1010, X_out[1]=6'b00_0101, X_out[2]=6'b00_0110, hard_bit=0.
REQ-034 SHALL cover saturation: L=−15, all C_in=−15 -> every X_out[i]=6'b11_1111, hard_bit=1; plus negative-zero inputs with L=0 -> X_out=0.
REQ-035 SHALL cover stall: en=0 for 3 cycles after a beat is accepted -> out_valid is asserted only on the second enabled cycle, and values are unchanged.
REQ-036 SHALL cover bypass and counter saturation: llr_load=1 with in_valid=1 and llr_in=−4 -> output uses −4 and iter_cnt=1; then 20 beats -> iter_cnt=15.

Source files
------------

// File: rtl/vnu.sv
// Degree-3 variable node for min-sum LDPC decoding: two-stage pipeline that sums the
// channel LLR with three check messages and emits extrinsic sign-magnitude messages.
module vnu (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            llr_load,
  input  logic [4:0]      llr_in,
  input  logic            init,
  input  logic            in_valid,
  input  logic [2:0][4:0] C_in,
  output logic [2:0][5:0] X_out,
  output logic            out_valid,
  output logic            hard_bit,
  output logic [3:0]      iter_cnt
);

  // Sign-magnitude to 7-bit two's complement; negative zero maps to 0.
  function automatic logic [6:0] sm2tc(input logic [4:0] sm);
    logic [6:0] m;
    m = {3'b000, sm[3:0]};
    return sm[4] ? (~m + 7'd1) : m;
  endfunction

  logic [4:0]      llr_q, llr_d;
  logic [3:0]      iter_q, iter_d;
  logic            s1_valid_q, s1_valid_d;
  logic [6:0]      total_q, total_d;
  logic [6:0]      c_q [3];
  logic [6:0]      c_d [3];
  logic            ov_q, ov_d;
  logic            hard_q, hard_d;
  logic [2:0][5:0] x_q, x_d;

  logic [6:0]      l_sel;
  logic [7:0]      ext [3];
  logic [7:0]      ext_abs [3];

  always_comb begin
    llr_d      = llr_q;
    iter_d     = iter_q;
    s1_valid_d = in_valid;
    total_d    = total_q;
    for (int i = 0; i < 3; i++) c_d[i] = c_q[i];
    ov_d       = s1_valid_q;
    hard_d     = hard_q;
    x_d        = x_q;

    if (llr_load) llr_d = llr_in;

    // Same-cycle load feeds the new LLR straight into stage 1.
    l_sel = llr_load ? sm2tc(llr_in) : sm2tc(llr_q);

    if (in_valid) begin
      for (int i = 0; i < 3; i++) c_d[i] = init ? 7'd0 : sm2tc(C_in[i]);
      total_d = l_sel + c_d[0] + c_d[1] + c_d[2];
    end

    if (llr_load)
      iter_d = in_valid ? 4'd1 : 4'd0;
    else if (in_valid && iter_q != 4'd15)
      iter_d = iter_q + 4'd1;

    for (int i = 0; i < 3; i++) begin
      ext[i]     = {total_q[6], total_q} - {c_q[i][6], c_q[i]};
      ext_abs[i] = ext[i][7] ? (~ext[i] + 8'd1) : ext[i];
    end

    if (s1_valid_q) begin
      hard_d = total_q[6];
      for (int i = 0; i < 3; i++)
        x_d[i] = {total_q[6], ext[i][7], (ext_abs[i] > 8'd15) ? 4'hf : ext_abs[i][3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      llr_q      <= '0;
      iter_q     <= '0;
      s1_valid_q <= 1'b0;
      total_q    <= '0;
      for (int i = 0; i < 3; i++) c_q[i] <= '0;
      ov_q       <= 1'b0;
      hard_q     <= 1'b0;
      x_q        <= '0;
    end else if (en) begin
      llr_q      <= llr_d;
      iter_q     <= iter_d;
      s1_valid_q <= s1_valid_d;
      total_q    <= total_d;
      for (int i = 0; i < 3; i++) c_q[i] <= c_d[i];
      ov_q       <= ov_d;
      hard_q     <= hard_d;
      x_q        <= x_d;
    end
  end

  assign X_out     = x_q;
  assign out_valid = ov_q;
  assign hard_bit  = hard_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_vnu.sv
// Directed bench for vnu: vector table of single beats plus hand-written pipeline sequences.
module tb_vnu;

  logic            clk = 1'b0;
  logic            rst, en, llr_load, init, in_valid;
  logic [4:0]      llr_in;
  logic [2:0][4:0] C_in;
  logic [2:0][5:0] X_out;
  logic            out_valid, hard_bit;
  logic [3:0]      iter_cnt;

  int checks = 0;
  int errors = 0;

  vnu dut (
    .clk(clk), .rst(rst), .en(en), .llr_load(llr_load), .llr_in(llr_in),
    .init(init), .in_valid(in_valid), .C_in(C_in), .X_out(X_out),
    .out_valid(out_valid), .hard_bit(hard_bit), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      llr;
    logic [2:0][4:0] c;
    logic            ini;
    logic [2:0][5:0] x;
    logic            hard;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [2:0][5:0] x, input logic hard, input logic [3:0] it);
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " X_out"}, 32'(X_out), 32'(x));
    chk({name, " hard_bit"}, 32'(hard_bit), 32'(hard));
    chk({name, " iter_cnt"}, 32'(iter_cnt), 32'(it));
  endtask

  task automatic beat(input logic [2:0][4:0] c);
    in_valid = 1'b1; C_in = c; init = 1'b0;
    step();
    in_valid = 1'b0; C_in = '0;
  endtask

  task automatic load(input logic [4:0] l);
    llr_load = 1'b1; llr_in = l;
    step();
    llr_load = 1'b0;
  endtask

  initial begin
    // {llr, {C2,C1,C0}, init, {X2,X1,X0}, hard}
    vecs[0] = '{5'b00111, {5'b01111, 5'b01111, 5'b01111}, 1'b1, {6'b000111, 6'b000111, 6'b000111}, 1'b0};
    vecs[1] = '{5'b00111, {5'b00001, 5'b00010, 5'b10011}, 1'b0, {6'b000110, 6'b000101, 6'b001010}, 1'b0};
    vecs[2] = '{5'b11111, {5'b11111, 5'b11111, 5'b11111}, 1'b0, {6'b111111, 6'b111111, 6'b111111}, 1'b1};
    vecs[3] = '{5'b10000, {5'b10000, 5'b10000, 5'b10000}, 1'b0, {6'b000000, 6'b000000, 6'b000000}, 1'b0};
    vecs[4] = '{5'b01111, {5'b01111, 5'b01111, 5'b01111}, 1'b0, {6'b001111, 6'b001111, 6'b001111}, 1'b0};
    vecs[5] = '{5'b00001, {5'b00010, 5'b00000, 5'b10101}, 1'b0, {6'b110100, 6'b110010, 6'b100011}, 1'b1};
    vecs[6] = '{5'b10100, {5'b01111, 5'b01111, 5'b01111}, 1'b1, {6'b110100, 6'b110100, 6'b110100}, 1'b1};
    vecs[7] = '{5'b00000, {5'b00000, 5'b10011, 5'b00011}, 1'b0, {6'b000000, 6'b000011, 6'b010011}, 1'b0};

    rst = 1'b1; en = 1'b0; llr_load = 1'b0; llr_in = '0; init = 1'b0; in_valid = 1'b0; C_in = '0;
    step(); step();
    rst = 1'b0; en = 1'b1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset X_out", 32'(X_out), 32'd0);
    chk("reset hard_bit", 32'(hard_bit), 32'd0);
    chk("reset iter_cnt", 32'(iter_cnt), 32'd0);

    for (int v = 0; v < 8; v++) begin
      load(vecs[v].llr);
      in_valid = 1'b1; C_in = vecs[v].c; init = vecs[v].ini;
      step();
      in_valid = 1'b0; C_in = '0; init = 1'b0;
      step();
      chk_out($sformatf("vec%0d", v), vecs[v].x, vecs[v].hard, 4'd1);
    end

    step();
    chk("hold out_valid", 32'(out_valid), 32'd0);
    chk("hold X_out", 32'(X_out), 32'(vecs[7].x));
    chk("hold hard_bit", 32'(hard_bit), 32'd0);

    // Back-to-back beats, L=+2.
    load(5'b00010);
    in_valid = 1'b1; C_in = {5'b00001, 5'b00000, 5'b00000};
    step();
    C_in = {5'b00000, 5'b00000, 5'b10110};
    step();
    chk_out("b2b A", {6'b000010, 6'b000011, 6'b000011}, 1'b0, 4'd2);
    in_valid = 1'b0; C_in = '0;
    step();
    chk_out("b2b B", {6'b110100, 6'b110100, 6'b100010}, 1'b1, 4'd2);
    step();
    chk("b2b drop", 32'(out_valid), 32'd0);

    // Stall: loads and beats presented while en=0 must be ignored.
    load(5'b00011);
    beat('0);
    en = 1'b0; in_valid = 1'b1; llr_load = 1'b1; llr_in = 5'b11111; C_in = {3{5'b01111}};
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd0);
    end
    chk("stall iter_cnt", 32'(iter_cnt), 32'd1);
    en = 1'b1; in_valid = 1'b0; llr_load = 1'b0; C_in = '0;
    step();
    chk_out("stall out", {3{6'b000011}}, 1'b0, 4'd1);
    beat('0);
    step();
    chk_out("stall llr kept", {3{6'b000011}}, 1'b0, 4'd2);

    // llr_load while a beat is in flight.
    load(5'b00101);
    beat('0);
    llr_load = 1'b1; llr_in = 5'b10011;
    step();
    llr_load = 1'b0;
    chk_out("inflight old L", {3{6'b000101}}, 1'b0, 4'd0);
    beat('0);
    step();
    chk_out("inflight new L", {3{6'b110011}}, 1'b1, 4'd1);

    // Bypass and counter saturation.
    load(5'b01001);
    llr_load = 1'b1; llr_in = 5'b10100; in_valid = 1'b1; C_in = '0;
    step();
    llr_load = 1'b0; in_valid = 1'b0;
    step();
    chk_out("bypass", {3{6'b110100}}, 1'b1, 4'd1);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) step();
    in_valid = 1'b0;
    chk("sat iter_cnt", 32'(iter_cnt), 32'd15);
    chk("sat out_valid", 32'(out_valid), 32'd1);
    chk("sat X_out", 32'(X_out), 32'({3{6'b110100}}));

    // Reset with two beats in flight.
    step(); step();
    load(5'b00111);
    beat({5'b00001, 5'b00001, 5'b00001});
    in_valid = 1'b1; rst = 1'b1; C_in = {5'b00001, 5'b00001, 5'b00001};
    step();
    rst = 1'b0; in_valid = 1'b0; C_in = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d out_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("rst%0d X_out", k), 32'(X_out), 32'd0);
      chk($sformatf("rst%0d iter_cnt", k), 32'(iter_cnt), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
